// File: rtl/mem_copy_engine.sv
// Block-copy DMA master for the single-port word memory, with a running checksum; one word per two cycles, done 2*len+1 cycles after start.
// There is no backpressure: start is honoured only in IDLE, and requests made while busy or in DONE are dropped.
module mem_copy_engine #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] src_r, dst_r, len_r, cnt;
    logic [AW-1:0] cnt_inc;

    assign cnt_inc = cnt + {{(AW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (len == '0) ? S_DONE : S_RD;
            S_RD:   state_nxt = S_WR;
            S_WR:   state_nxt = (cnt_inc == len_r) ? S_DONE : S_RD;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transfer parameters are captured once; later input changes cannot disturb an ongoing copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_r    <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            cnt      <= '0;
            checksum <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                src_r    <= src_base;
                dst_r    <= dst_base;
                len_r    <= len;
                cnt      <= '0;
                checksum <= '0;
            end else if (state == S_WR) begin
                cnt      <= cnt_inc;
                checksum <= checksum + mem_rdata;
            end
        end
    end

    // The memory port decodes only from state and registers, so start never reaches it combinationally.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        case (state)
            S_RD: begin
                busy     = 1'b1;
                mem_addr = src_r + cnt;
            end
            S_WR: begin
                busy      = 1'b1;
                mem_addr  = dst_r + cnt;
                mem_wen   = 1'b1;
                mem_wdata = mem_rdata;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: registered-address word memory plus an ascending-copy reference model.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_base = '0, dst_base = '0, len = '0;
    logic        busy, done, mem_wen;
    logic [15:0] checksum, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad = 0;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] rd_q = '0;
    logic        h_we = 1'b0;
    logic [15:0] h_addr = '0, h_data = '0;
    logic [15:0] rd_log [$];

    always #5 clk = ~clk;

    mem_copy_engine #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done), .checksum(checksum),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        rd_q <= mem_addr;
        if (mem_wen)   mem[mem_addr] <= mem_wdata;
        else if (h_we) mem[h_addr]   <= h_data;
    end
    assign mem_rdata = mem[rd_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [15:0] a, input logic [15:0] v);
        h_we = 1'b1; h_addr = a; h_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        h_we = 1'b0;
    endtask

    // Reference: ascending word-by-word copy with 16-bit address wrap; returns the sum of words written.
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                              output logic [15:0] sum);
        sum = '0;
        for (int i = 0; i < int'(n); i++) begin
            logic [15:0] sa, da;
            sa = s + 16'(i);
            da = d + 16'(i);
            ref_mem[da] = ref_mem[sa];
            sum = sum + ref_mem[sa];
        end
    endtask

    // Issues one start and steps until done (bounded); optionally pokes a second start at cycle poke.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                            input int poke, output int done_at, output int wens, output int busy_n);
        int budget;
        budget = 2 * int'(n) + 10;
        src_base = s; dst_base = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_base = 16'($urandom); dst_base = 16'($urandom); len = 16'($urandom);
        done_at = 0; wens = 0; busy_n = 0;
        rd_log.delete();
        for (int k = 1; k <= budget && done_at == 0; k++) begin
            if (mem_wen) wens++;
            if (busy) busy_n++;
            if (busy && !mem_wen) rd_log.push_back(mem_addr);
            if (done) done_at = k;
            if (k == poke) begin
                start = 1'b1; len = 16'd8;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        int          dat, wn, bn;
        logic [15:0] sum, s, d, n, a;
        logic [15:0] sv [4];

        for (int i = 0; i < 65536; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wen", 32'(mem_wen), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_cksum", 32'(checksum), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic copy
        for (int i = 0; i < 4; i++) host_write(16'h0010 + 16'(i), 16'(i + 1));
        run_copy(16'h0010, 16'h0080, 16'd4, 0, dat, wn, bn);
        model_copy(16'h0010, 16'h0080, 16'd4, sum);
        chk("basic_done_at", 32'(dat), 9);
        chk("basic_wens", 32'(wn), 4);
        chk("basic_busy_cycles", 32'(bn), 8);
        chk("basic_cksum", 32'(checksum), 32'h000A);
        chk("basic_cksum_model", 32'(checksum), 32'(sum));
        for (int i = 0; i < 4; i++) begin
            chk("basic_dst", 32'(mem[16'h0080 + 16'(i)]), 32'(i + 1));
            chk("basic_src", 32'(mem[16'h0010 + 16'(i)]), 32'(i + 1));
        end
        chk("basic_done_single", 32'(done), 0);

        // Zero length
        run_copy(16'h0010, 16'h0200, 16'd0, 0, dat, wn, bn);
        chk("zero_done_at", 32'(dat), 1);
        chk("zero_wens", 32'(wn), 0);
        chk("zero_busy", 32'(bn), 0);
        chk("zero_cksum", 32'(checksum), 0);

        // Wrap and overflow
        host_write(16'hFFFE, 16'hFFFF);
        host_write(16'hFFFF, 16'h0002);
        host_write(16'h0000, 16'h0000);
        run_copy(16'hFFFE, 16'h0100, 16'd3, 0, dat, wn, bn);
        model_copy(16'hFFFE, 16'h0100, 16'd3, sum);
        chk("wrap_reads_n", 32'(rd_log.size()), 3);
        if (rd_log.size() == 3) begin
            chk("wrap_rd0", 32'(rd_log[0]), 32'hFFFE);
            chk("wrap_rd1", 32'(rd_log[1]), 32'hFFFF);
            chk("wrap_rd2", 32'(rd_log[2]), 32'h0000);
        end
        chk("wrap_d0", 32'(mem[16'h0100]), 32'hFFFF);
        chk("wrap_d1", 32'(mem[16'h0101]), 32'h0002);
        chk("wrap_d2", 32'(mem[16'h0102]), 32'h0000);
        chk("wrap_cksum", 32'(checksum), 32'h0001);
        chk("wrap_cksum_model", 32'(checksum), 32'(sum));

        // Ignored start mid-transfer
        for (int i = 0; i < 8; i++) host_write(16'h0300 + 16'(i), 16'($urandom));
        run_copy(16'h0300, 16'h0400, 16'd3, 4, dat, wn, bn);
        model_copy(16'h0300, 16'h0400, 16'd3, sum);
        chk("ign_done_at", 32'(dat), 7);
        chk("ign_wens", 32'(wn), 3);
        chk("ign_idle_busy", 32'(busy), 0);
        chk("ign_idle_done", 32'(done), 0);
        chk("ign_cksum", 32'(checksum), 32'(sum));
        chk("ign_no_word3", 32'(mem[16'h0403]), 32'(ref_mem[16'h0403]));
        repeat (3) begin
            @(posedge clk); #1;
            chk("ign_stays_idle", 32'({busy, done, mem_wen}), 0);
        end

        // Overlap: dst inside source window
        host_write(16'h0020, 16'h000A);
        host_write(16'h0021, 16'h000B);
        host_write(16'h0022, 16'h000C);
        run_copy(16'h0020, 16'h0021, 16'd2, 0, dat, wn, bn);
        model_copy(16'h0020, 16'h0021, 16'd2, sum);
        chk("ovl_m21", 32'(mem[16'h0021]), 32'h000A);
        chk("ovl_m22", 32'(mem[16'h0022]), 32'h000A);
        chk("ovl_cksum", 32'(checksum), 32'h0014);
        chk("ovl_model", 32'(mem[16'h0022]), 32'(ref_mem[16'h0022]));

        // Reset mid-op during WR of word index 2
        for (int i = 0; i < 4; i++) begin
            sv[i] = 16'($urandom_range(1, 16'hFFFF));
            host_write(16'h0040 + 16'(i), sv[i]);
            host_write(16'h0090 + 16'(i), 16'h5555 + 16'(i));
        end
        src_base = 16'h0040; dst_base = 16'h0090; len = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("rmid_in_wr", 32'({busy, mem_wen}), 32'b11);
        rst = 1'b0;
        #1;
        chk("rmid_wen_drop", 32'(mem_wen), 0);
        chk("rmid_busy_drop", 32'(busy), 0);
        chk("rmid_addr", 32'(mem_addr), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rmid_w0", 32'(mem[16'h0090]), 32'(sv[0]));
        chk("rmid_w1", 32'(mem[16'h0091]), 32'(sv[1]));
        chk("rmid_w2", 32'(mem[16'h0092]), 32'h5557);
        chk("rmid_w3", 32'(mem[16'h0093]), 32'h5558);
        chk("rmid_post_cksum", 32'(checksum), 0);
        chk("rmid_post_outs", 32'({busy, done, mem_wen, mem_addr, mem_wdata}), 0);
        ref_mem[16'h0090] = sv[0];
        ref_mem[16'h0091] = sv[1];
        @(posedge clk); #1;
        run_copy(16'h0040, 16'h0090, 16'd4, 0, dat, wn, bn);
        model_copy(16'h0040, 16'h0090, 16'd4, sum);
        chk("rmid_restart_done", 32'(dat), 9);
        chk("rmid_restart_cksum", 32'(checksum), 32'(sum));
        chk("rmid_restart_w3", 32'(mem[16'h0093]), 32'(sv[3]));

        // Randomized transfers against the reference model
        for (int t = 0; t < 6; t++) begin
            s = 16'($urandom);
            d = (t % 2 == 0) ? 16'($urandom) : s + 16'($urandom_range(0, 6));
            n = 16'($urandom_range(1, 12));
            for (int i = 0; i < int'(n); i++) host_write(s + 16'(i), 16'($urandom));
            run_copy(s, d, n, 0, dat, wn, bn);
            model_copy(s, d, n, sum);
            chk("rnd_done_at", 32'(dat), 2 * int'(n) + 1);
            chk("rnd_wens", 32'(wn), 32'(n));
            chk("rnd_cksum", 32'(checksum), 32'(sum));
            for (int i = 0; i < int'(n) + 6; i++) begin
                a = d + 16'(i);
                chk("rnd_dst", 32'(mem[a]), 32'(ref_mem[a]));
            end
        end

        // Checksum holds after done
        repeat (4) @(posedge clk);
        #1;
        chk("cksum_hold", 32'(checksum), 32'(sum));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side master for the single-port word memory: drives `mem_addr`, `mem_wen` and `mem_wdata`, and consumes `mem_rdata`.
- Copies a block of `len` words from `src_base` to `dst_base` over the same port, accounting for the memory's one-cycle registered-address read latency.
- Sits beside the CPU as a simple DMA for block moves and for data-memory initialisation/scrubbing.
- Also produces a running checksum of the copied words for self-check.

Parameters:
- AW, 16, address width (matches ISIZE).
- DW, 16, data word width (matches DSIZE).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- src_base  in  AW  first source word address; latched at accepted start.
- dst_base  in  AW  first destination word address; latched at accepted start.
- len  in  AW  number of words to copy; latched at accepted start.
- busy  out  1  high while in RD or WR.
- done  out  1  single-cycle completion pulse.
- checksum  out  DW  sum of all words written this transfer, mod 2^DW.
- mem_addr  out  AW  memory address.
- mem_wen  out  1  memory write enable, active-high.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data: word at the address presented in the previous cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, checksum=0, latched bases/len=0. Outputs busy=0, done=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- Reset mid-transfer aborts immediately. mem_wen drops asynchronously. Words already written stay written; no further access occurs.
- States: IDLE, RD, WR, DONE. Memory outputs decode from state and registers only; no combinational path from start to the memory port.
- IDLE:
  - Port outputs: mem_wen=0, mem_addr=0, mem_wdata=0.
  - On edge with start=1: latch src_base, dst_base, len; clear cnt and checksum.
  - If len=0, go to DONE; else go to RD.
- RD:
  - mem_addr = src_r + cnt (mod 2^AW); mem_wen=0; mem_wdata=0.
  - The memory registers the address at the edge. Next state WR.
- WR:
  - mem_addr = dst_r + cnt (mod 2^AW); mem_wen=1; mem_wdata = mem_rdata (the source word, valid this cycle).
  - At the edge: the memory writes; checksum += mem_wdata (mod 2^DW); cnt += 1.
  - Next state DONE if cnt+1 == len_r, else RD.
- DONE: done=1 for exactly one cycle; busy=0; port outputs idle as in IDLE. Next state IDLE.
- Latency: for len=N>0, the start edge is followed by 2N cycles of RD/WR, then the DONE cycle. done is high in the (2N+1)th cycle after the start edge.
- Throughput: one word per 2 cycles. Next start is accepted no earlier than the cycle after DONE.
- start while busy or in DONE: ignored, no queueing. Changes to src_base/dst_base/len after the accepted start: no effect.
- checksum holds its final value after done until the next accepted start clears it.
- Addresses wrap modulo 2^AW; 0xFFFF+1 → 0x0000.
- Copy order is strictly ascending. Overlapping regions get no protection: with dst inside (src, src+len), later reads see already-copied data. This is defined behaviour and must match this ordering exactly.
- len = 2^AW-1 is the maximum transfer; cnt is AW bits wide.

Test Plan:
- Basic copy: mem[0x0010..0x0013]=0x0001,0x0002,0x0003,0x0004; start with src=0x0010, dst=0x0080, len=4 → exactly 4 mem_wen pulses on alternate cycles; done high 9 cycles after the start edge; mem[0x0080..0x0083]=0x0001..0x0004; checksum=0x000A; source unchanged.
- Zero length: start with len=0 → done high the cycle after the start edge; mem_wen never asserted; busy never high; checksum=0x0000.
- Wrap and overflow: mem[0xFFFE]=0xFFFF, mem[0xFFFF]=0x0002, mem[0x0000]=0x0000; src=0xFFFE, dst=0x0100, len=3 → reads at 0xFFFE, 0xFFFF, 0x0000; mem[0x0100..0x0102]=0xFFFF,0x0002,0x0000; checksum=0x0001.
- Ignored start: pulse start with len=8 four cycles into a len=3 transfer, and change len mid-transfer → only 3 words copied; single done at the 7th cycle after the original start edge; engine back in IDLE.
- Overlap: mem[0x20..0x22]=0xA,0xB,0xC; src=0x20, dst=0x21, len=2 → mem[0x21]=0xA, mem[0x22]=0xA; checksum=0x0014.
- Reset mid-op: len=4; assert rst=0 while in WR of word index 2 → mem_wen and busy drop immediately; dst words 0 and 1 written, words 2 and 3 not; after release, outputs hold reset values and a new start works normally.
